// File: rtl/divu_seq.sv
// Sequential unsigned divider: radix-2 restoring division, one quotient bit per clock.
// Quotient returns in lo, remainder in hi; divide-by-zero yields lo=all ones, hi=dividend.
module divu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted, trial;

  // rem never exceeds dvs-1, so its top (WIDTH+1-th) bit is always zero and is not stored
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // quo doubles as the dividend latch on the divide-by-zero path
          dvs   <= divisor;
          quo   <= dividend;
          rem   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= (divisor == '0) ? FIN : RUN;
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (dvs == '0) begin
            lo          <= '1;
            hi          <= quo;
            div_by_zero <= 1'b1;
          end else begin
            lo          <= quo;
            hi          <= rem;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
